// File: rtl/llr_load_ctrl_pkg.sv
// Shared constants and state encoding for the LLR memory load controller.
package llr_load_ctrl_pkg;

    localparam int unsigned N_WORDS = 128;  // 64-bit words per frame
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned POS_W   = 10;
    localparam int unsigned MAX_POS = 1022; // highest legal physical position
    localparam int unsigned N_PORTS = 6;    // memory read ports
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned BEAT_W  = $clog2(N_WORDS);

    localparam logic [1:0] IDLE_ENC = 2'd0;
    localparam logic [1:0] LOAD_ENC = 2'd1;
    localparam logic [1:0] FULL_ENC = 2'd2;

    typedef enum logic [1:0] {
        StIdle = IDLE_ENC,
        StLoad = LOAD_ENC,
        StFull = FULL_ENC
    } state_e;

endpackage

// File: rtl/llr_load_ctrl_if.sv
// Channel-word stream into the load controller (valid/ready with frame delimiter).
interface llr_load_ctrl_if;
    import llr_load_ctrl_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/llr_load_ctrl.sv
// Sequences one frame into the LLR shift memory, then gates the decoder's 6-port reads
// until the decoder releases the frame.
module llr_load_ctrl
    import llr_load_ctrl_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    llr_load_ctrl_if.slave           io_in,
    output logic                     o_mem_wen,
    output logic [DATA_W-1:0]        o_mem_data,
    output logic                     o_frame_valid,
    input  logic                     i_dec_rd_req,
    input  logic [N_PORTS*POS_W-1:0] i_dec_pos,
    output logic [N_PORTS*POS_W-1:0] o_mem_pos,
    output logic                     o_rd_valid,
    input  logic                     i_dec_done,
    output logic                     o_len_err,
    output logic                     o_rd_err,
    output logic [CNT_W-1:0]         o_frame_cnt
);

    state_e             r_state, w_state_nxt;
    logic [BEAT_W-1:0]  r_count, w_count_nxt;
    logic [CNT_W-1:0]   r_frame_cnt, w_frame_cnt_nxt;
    logic               r_len_err, w_len_err_nxt;
    logic               r_rd_valid;
    logic               r_rd_err;
    logic               w_accept;
    logic               w_final_beat;
    logic               w_rd_ok;
    logic [N_PORTS-1:0] w_pos_ok;

    // Per-port range check; position 1023 is not a physical entry.
    for (genvar g = 0; g < N_PORTS; g++) begin : g_pos_chk
        assign w_pos_ok[g] = (i_dec_pos[g*POS_W +: POS_W] <= POS_W'(MAX_POS));
    end

    // Ready depends on state only, so there is no valid-to-ready path.
    assign io_in.in_ready = (r_state != StFull);
    assign w_accept       = io_in.in_valid & io_in.in_ready;
    // r_count holds beats already accepted, so 127 means this is beat 128.
    assign w_final_beat   = (r_count == BEAT_W'(N_WORDS - 1));
    assign w_rd_ok        = (r_state == StFull) & (&w_pos_ok);

    assign o_mem_wen     = w_accept;
    assign o_mem_data    = io_in.in_data;
    assign o_mem_pos     = i_dec_pos;
    assign o_frame_valid = (r_state == StFull);
    assign o_rd_valid    = r_rd_valid;
    assign o_rd_err      = r_rd_err;
    assign o_len_err     = r_len_err;
    assign o_frame_cnt   = r_frame_cnt;

    // Next-state: beat counting, length checks and frame release.
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_frame_cnt_nxt = r_frame_cnt;
        w_len_err_nxt   = 1'b0;
        unique case (r_state)
            StIdle, StLoad: begin
                if (w_accept) begin
                    if (w_final_beat) begin
                        w_state_nxt   = StFull;
                        w_count_nxt   = '0;
                        w_len_err_nxt = ~io_in.in_last;
                    end else if (io_in.in_last) begin
                        // Short frame: drop it; the next frame overwrites every entry.
                        w_state_nxt   = StIdle;
                        w_count_nxt   = '0;
                        w_len_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = StLoad;
                        w_count_nxt = r_count + 1'b1;
                    end
                end
            end
            StFull: begin
                if (i_dec_done) begin
                    w_state_nxt     = StIdle;
                    w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_count_nxt = '0;
            end
        endcase
    end

    // State and registered pulses; read qualifiers line up with the 1-cycle memory latency.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_count     <= '0;
            r_frame_cnt <= '0;
            r_len_err   <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_err    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_len_err   <= w_len_err_nxt;
            r_rd_valid  <= i_dec_rd_req & w_rd_ok;
            r_rd_err    <= i_dec_rd_req & ~w_rd_ok;
        end
    end

endmodule
